mem_data_bus_if: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register.
- Turns a decoded load/store request (address, store data, size, signedness) into a Wishbone classic single-transfer master cycle on the data bus.
- Requests a pipeline stall until the transfer completes, returns the aligned and extended load result, and reports misalignment and bus timeout.
- Sits between the EX/MEM register outputs and the MEM/WB register.

---
 rtl/mem_data_bus_if.sv | 161 ++++++++++++++++
 tb/tb_mem_data_bus_if.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_bus_if.sv
// MEM-stage load/store unit: issues one Wishbone classic transfer per request,
// stalls the pipe until ack, returns the aligned/extended load result.
module mem_data_bus_if #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stallreq,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rbuf;
  logic [1:0]       sz_q, off_q;
  logic             uns_q;
  logic             size_ok, misal, go, take_ack;
  logic [3:0]       sel_d;
  logic [31:0]      dat_d, ext_ack;

  // Big-endian lane select: address offset 0 is the most significant byte.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign size_ok  = (req_size != 2'b11);
  assign misal    = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign addr_err = req_valid && size_ok && misal;
  assign go       = req_valid && size_ok && !misal && !flush;
  assign ext_ack  = extend(wb_dat_i, sz_q, off_q, uns_q);
  assign wb_stb_o = wb_cyc_o;

  always_comb begin
    sel_d = 4'b1111;
    dat_d = req_wdata;
    case (req_size)
      2'b00: begin
        sel_d = 4'b1000 >> req_addr[1:0];
        dat_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        sel_d = req_addr[1] ? 4'b0011 : 4'b1100;
        dat_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    stallreq    = 1'b0;
    rdata       = 32'b0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    take_ack    = 1'b0;
    case (state)
      IDLE: begin
        stallreq = go;
        if (go) state_nxt = BUS;
      end
      BUS: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (wb_ack_i) begin
          take_ack    = 1'b1;
          rdata       = ext_ack;
          rdata_valid = !wb_we_o;
          state_nxt   = pipe_stall ? HOLD : IDLE;
        end else if (cnt == CNT_LAST) begin
          bus_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end
      HOLD: begin
        rdata       = rbuf;
        rdata_valid = !wb_we_o;
        if (!pipe_stall || flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rbuf     <= 32'b0;
      sz_q     <= 2'b0;
      off_q    <= 2'b0;
      uns_q    <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'b0;
      wb_sel_o <= 4'b0;
      wb_dat_o <= 32'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= req_we;
        wb_adr_o <= {req_addr[31:2], 2'b00};
        wb_sel_o <= sel_d;
        wb_dat_o <= dat_d;
        sz_q     <= req_size;
        off_q    <= req_addr[1:0];
        uns_q    <= req_unsigned;
        cnt      <= '0;
      end
      if (state == BUS) begin
        cnt <= cnt + CNT_ONE;
        if (state_nxt != BUS) wb_cyc_o <= 1'b0;
      end
      if (take_ack) rbuf <= ext_ack;
    end
  end

endmodule

// File: tb/tb_mem_data_bus_if.sv
// Randomized plus directed bench for mem_data_bus_if against a transaction-level model.
module tb_mem_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, flush, pipe_stall;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stallreq, rdata_valid, addr_err, bus_err;
  logic [31:0] rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  int n_cmp = 0;
  int n_mis = 0;

  mem_data_bus_if #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .pipe_stall(pipe_stall),
    .stallreq(stallreq), .rdata(rdata), .rdata_valid(rdata_valid),
    .addr_err(addr_err), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc_step();
    @(negedge clk);
  endtask

  // One complete transfer: issue, ack after ack_at BUS cycles, optional HOLD for hold cycles.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                      input logic [31:0] rd, input int hold);
    int          off;
    logic [3:0]  e_sel;
    logic [31:0] e_dat, e_rd;
    off = int'(addr[1:0]);
    case (sz)
      2'b00: begin
        e_sel = 4'b1000 >> off;
        e_dat = (wd & 32'hFF) * 32'h0101_0101;
        e_rd  = (rd >> (8 * (3 - off))) & 32'hFF;
        if (!uns && e_rd >= 32'h80) e_rd = e_rd | 32'hFFFF_FF00;
      end
      2'b01: begin
        e_sel = 4'b1100 >> off;
        e_dat = (wd & 32'hFFFF) * 32'h0001_0001;
        e_rd  = (rd >> (8 * (2 - off))) & 32'hFFFF;
        if (!uns && e_rd >= 32'h8000) e_rd = e_rd | 32'hFFFF_0000;
      end
      default: begin
        e_sel = 4'b1111;
        e_dat = wd;
        e_rd  = rd;
      end
    endcase
    cyc_step();
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; pipe_stall = 1'b0; wb_ack_i = 1'b0; flush = 1'b0;
    #1;
    chk("issue_stall", 32'(stallreq), 32'd1);
    chk("issue_cyc", 32'(wb_cyc_o), 32'd0);
    for (int k = 1; k <= ack_at; k++) begin
      cyc_step();
      wb_ack_i = (k == ack_at);
      wb_dat_i = rd;
      pipe_stall = (k == ack_at) && (hold > 0);
      #1;
      chk("bus_cyc", 32'(wb_cyc_o), 32'd1);
      chk("bus_stb", 32'(wb_stb_o), 32'd1);
      if (k == 1) begin
        chk("bus_we", 32'(wb_we_o), 32'(we));
        chk("bus_adr", wb_adr_o, addr & 32'hFFFF_FFFC);
        chk("bus_sel", 32'(wb_sel_o), 32'(e_sel));
        if (we) chk("bus_dat_o", wb_dat_o, e_dat);
      end
      if (k < ack_at) begin
        chk("wait_stall", 32'(stallreq), 32'd1);
      end else begin
        chk("ack_stall", 32'(stallreq), 32'd0);
        chk("ack_rvalid", 32'(rdata_valid), 32'(!we));
        if (!we) chk("ack_rdata", rdata, e_rd);
      end
    end
    for (int h = 1; h <= hold; h++) begin
      cyc_step();
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
      pipe_stall = (h < hold);
      #1;
      chk("hold_cyc", 32'(wb_cyc_o), 32'd0);
      chk("hold_stall", 32'(stallreq), 32'd0);
      chk("hold_rvalid", 32'(rdata_valid), 32'(!we));
      if (!we) chk("hold_rdata", rdata, e_rd);
    end
    cyc_step();
    req_valid = 1'b0; wb_ack_i = 1'b0; pipe_stall = 1'b0;
    #1;
    chk("idle_cyc", 32'(wb_cyc_o), 32'd0);
    chk("idle_stall", 32'(stallreq), 32'd0);
    chk("idle_rvalid", 32'(rdata_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'b0; req_wdata = 32'b0; flush = 1'b0; pipe_stall = 1'b0;
    wb_ack_i = 1'b0; wb_dat_i = 32'b0;
    #3;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_rvalid", 32'(rdata_valid), 32'd0);
    cyc_step();
    rst = 1'b1;

    // Directed cases
    xfer(1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0, 3, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 1, 32'h1234_56F0, 0);
    xfer(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 2, 32'h1234_56F0, 0);
    xfer(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 2, 32'h5555_5555, 0);
    xfer(1'b0, 2'b01, 1'b0, 32'h0000_4000, 32'h0, 1, 32'h8001_7FFF, 3);

    // Misaligned half: no bus cycle at all
    cyc_step();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_addr = 32'h0000_5001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mis_addr_err", 32'(addr_err), 32'd1);
      chk("mis_stall", 32'(stallreq), 32'd0);
      chk("mis_cyc", 32'(wb_cyc_o), 32'd0);
      cyc_step();
    end
    req_size = 2'b11; req_addr = 32'h0000_5000;
    #1;
    chk("illegal_stall", 32'(stallreq), 32'd0);
    chk("illegal_addr_err", 32'(addr_err), 32'd0);
    req_valid = 1'b0;

    // Timeout with TIMEOUT=4
    cyc_step();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_6000;
    for (int k = 1; k <= 6; k++) begin
      cyc_step();
      if (k >= 4) req_valid = 1'b0;
      #1;
      chk("to_cyc", 32'(wb_cyc_o), 32'(k <= 4));
      chk("to_bus_err", 32'(bus_err), 32'(k == 4));
      chk("to_stall", 32'(stallreq), 32'(k < 4));
    end

    // Flush in the second BUS cycle
    cyc_step();
    req_valid = 1'b1; req_addr = 32'h0000_7000;
    cyc_step();
    #1;
    chk("fl_cyc1", 32'(wb_cyc_o), 32'd1);
    cyc_step();
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stallreq), 32'd0);
    chk("fl_rvalid", 32'(rdata_valid), 32'd0);
    chk("fl_bus_err", 32'(bus_err), 32'd0);
    cyc_step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("fl_cyc_drop", 32'(wb_cyc_o), 32'd0);
    chk("fl_no_err", 32'(bus_err), 32'd0);

    // Stray ack in IDLE is ignored
    cyc_step();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    #1;
    chk("stray_rvalid", 32'(rdata_valid), 32'd0);
    chk("stray_rdata", rdata, 32'd0);
    cyc_step();
    wb_ack_i = 1'b0;

    // Randomized aligned transfers
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      xfer(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(1, 4),
           $urandom, $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
    end

    // Asynchronous reset mid-BUS
    cyc_step();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_8000;
    cyc_step();
    #1;
    chk("ar_cyc_before", 32'(wb_cyc_o), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_cyc_after", 32'(wb_cyc_o), 32'd0);
    chk("ar_adr_after", wb_adr_o, 32'd0);
    req_valid = 1'b0;
    cyc_step();
    rst = 1'b1;
    cyc_step();
    #1;
    chk("ar_idle_cyc", 32'(wb_cyc_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
